two_to_four_rr_arbiter: RTL and testbench

TWO_TO_FOUR_RR_ARBITER -- requirements
Module: two_to_four_rr_arbiter

---
 rtl/two_to_four_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_two_to_four_rr_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/two_to_four_rr_arbiter.sv
// Round-robin arbiter for four requesters with a bounded hold time and a
// one-cycle gap between grants; all outputs come straight from registers.
module two_to_four_rr_arbiter #(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt_n,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_n_q, gnt_n_d;
   logic [1:0] gnt_idx_q, gnt_idx_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hcnt_q, hcnt_d;

   logic [1:0] winner;
   logic [1:0] cand;
   logic       found;

   // Search upward from the pointer; the first asserted request wins.
   always_comb begin
      winner = ptr_q;
      cand   = ptr_q;
      found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_n_d   = gnt_n_q;
      gnt_idx_d = gnt_idx_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      unique case (state_q)
         IDLE, GAP: begin
            if (found) begin
               state_d   = GRANT;
               gnt_n_d   = ~(4'b0001 << winner);
               gnt_idx_d = winner;
               busy_d    = 1'b1;
               ptr_d     = winner + 2'd1;
               hcnt_d    = 8'd0;
            end else begin
               state_d = IDLE;
               gnt_n_d = 4'b1111;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            if (!req[gnt_idx_q]) begin
               state_d = GAP;
               gnt_n_d = 4'b1111;
               busy_d  = 1'b0;
            end else if (hcnt_q == HOLD_LAST) begin
               // Owner still wants it but has used up its slot: revoke.
               state_d   = GAP;
               gnt_n_d   = 4'b1111;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_n_d = 4'b1111;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_n_q   <= 4'b1111;
         gnt_idx_q <= 2'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= 2'd0;
         hcnt_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         gnt_n_q   <= gnt_n_d;
         gnt_idx_q <= gnt_idx_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
      end
   end

   assign gnt_n   = gnt_n_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_two_to_four_rr_arbiter.sv
// Drives two arbiters (long and short hold limit) with the same requests and
// compares both against a behavioural model every cycle.
module tb_two_to_four_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gntN    [2];
   logic [1:0] gntIdx  [2];
   logic       busy    [2];
   logic       timeout [2];

   int vectorCount   = 0;
   int miscompareCount = 0;

   // Model state per instance: owner is -1 when nobody holds the grant.
   int mOwner [2];
   int mLast  [2];
   int mPtr   [2];
   int mHold  [2];
   bit mGap   [2];
   bit mTo    [2];
   int maxHold [2] = '{15, 4};

   two_to_four_rr_arbiter #(.MAX_HOLD(15)) dutA (
      .clk(clk), .rst(rst), .req(req),
      .gnt_n(gntN[0]), .gnt_idx(gntIdx[0]), .busy(busy[0]), .timeout(timeout[0])
   );

   two_to_four_rr_arbiter #(.MAX_HOLD(4)) dutB (
      .clk(clk), .rst(rst), .req(req),
      .gnt_n(gntN[1]), .gnt_idx(gntIdx[1]), .busy(busy[1]), .timeout(timeout[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelStep(input int i);
      if (rst) begin
         mOwner[i] = -1; mLast[i] = 0; mPtr[i] = 0; mHold[i] = 0;
         mGap[i] = 0; mTo[i] = 0;
      end else if (mOwner[i] >= 0) begin
         mTo[i] = 0;
         if (!req[mOwner[i]]) begin
            mOwner[i] = -1; mGap[i] = 1;
         end else if (mHold[i] == maxHold[i] - 1) begin
            mOwner[i] = -1; mGap[i] = 1; mTo[i] = 1;
         end else begin
            mHold[i]++;
         end
      end else begin
         mTo[i] = 0; mGap[i] = 0;
         for (int k = 0; k < 4; k++) begin
            int c;
            c = (mPtr[i] + k) % 4;
            if (mOwner[i] < 0 && req[c]) begin
               mOwner[i] = c; mLast[i] = c; mPtr[i] = (c + 1) % 4; mHold[i] = 0;
            end
         end
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         logic [3:0] expGnt;
         string      who;
         who    = (i == 0) ? "A" : "B";
         expGnt = 4'hF;
         if (mOwner[i] >= 0) expGnt[mOwner[i]] = 1'b0;
         checkOutput({who, ".gnt_n"},   8'(gntN[i]),   8'(expGnt));
         checkOutput({who, ".gnt_idx"}, 8'(gntIdx[i]), 8'(mLast[i]));
         checkOutput({who, ".busy"},    8'(busy[i]),   8'(mOwner[i] >= 0));
         checkOutput({who, ".timeout"}, 8'(timeout[i]), 8'(mTo[i]));
         checkOutput({who, ".onecold"}, 8'($countones(~gntN[i]) <= 1), 8'd1);
         if (mGap[i]) checkOutput({who, ".gapgrant"}, 8'(gntN[i]), 8'hF);
      end
   endtask

   // One clock: present inputs, let both the DUTs and the model take the edge.
   task automatic applyStimulus(input logic [3:0] newReq, input logic newRst);
      req = newReq;
      rst = newRst;
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      #1;
      checkAll();
   endtask

   initial begin
      req = 4'b0000;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mOwner[i] = -1; mLast[i] = 0; mPtr[i] = 0; mHold[i] = 0; mGap[i] = 0; mTo[i] = 0;
      end

      // Reset and single request held five cycles.
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      for (int n = 0; n < 5; n++) applyStimulus(4'b0100, 1'b0);
      checkOutput("single.idx", 8'(gntIdx[0]), 8'd2);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single.gap", 8'(gntN[0]), 8'hF);
      applyStimulus(4'b0000, 1'b0);

      // Round-robin with each owner releasing after two cycles.
      applyStimulus(4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1111, 1'b0);
         checkOutput("rr.order", 8'(gntIdx[0]), 8'(k % 4));
         applyStimulus(4'b1111, 1'b0);
         applyStimulus(4'b1111 & ~(4'b0001 << (k % 4)), 1'b0);
      end

      // Continuous requests: dutB times out at 4, dutA releases on its own.
      applyStimulus(4'b0000, 1'b1);
      for (int n = 0; n < 12; n++) applyStimulus(4'b0011, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);

      // Reset in the middle of a grant to requester 3.
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b1000, 1'b0);
      applyStimulus(4'b1000, 1'b0);
      applyStimulus(4'b1000, 1'b1);
      checkOutput("midrst.gnt", 8'(gntN[0]), 8'hF);
      applyStimulus(4'b1001, 1'b0);
      checkOutput("midrst.win", 8'(gntIdx[0]), 8'd0);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);

      // Late arrival of requester 0 while 1 owns the grant.
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0010, 1'b0);
      applyStimulus(4'b0011, 1'b0);
      applyStimulus(4'b0011, 1'b0);
      checkOutput("late.keep", 8'(gntIdx[0]), 8'd1);
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      checkOutput("late.win", 8'(gntIdx[0]), 8'd0);
      applyStimulus(4'b0000, 1'b0);

      // Random traffic: bits toggle occasionally, rare resets.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] flip;
         logic       r;
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 99) == 0);
         applyStimulus(req ^ flip, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
